// File: rtl/mini_alu_pkg.sv
// Shared definitions for mini_alu_core: opcodes, instruction field positions,
// fault codes and the core state encoding.
package mini_alu_pkg;

  localparam int unsigned InstrW = 28;

  // Instruction fields: op[27:24] dst[23:16] src1[15:8] src0[7:0], imm = {src1, src0}
  localparam int unsigned OpMsb   = 27;
  localparam int unsigned OpLsb   = 24;
  localparam int unsigned DstMsb  = 23;
  localparam int unsigned DstLsb  = 16;
  localparam int unsigned Src1Msb = 15;
  localparam int unsigned Src1Lsb = 8;
  localparam int unsigned Src0Msb = 7;
  localparam int unsigned Src0Lsb = 0;

  localparam logic [InstrW-1:0] InstrNop = '0;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpSto  = 4'h3;
  localparam logic [3:0] OpBle  = 4'h4;
  localparam logic [3:0] OpJmp  = 4'h5;
  localparam logic [3:0] OpCall = 4'h6;
  localparam logic [3:0] OpRet  = 4'h7;
  localparam logic [3:0] OpLed  = 4'h8;
  localparam logic [3:0] OpMul  = 4'h9;
  localparam logic [3:0] OpOut  = 4'hA;
  localparam logic [3:0] OpBeq  = 4'hB;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [1:0] FaultNone      = 2'd0;
  localparam logic [1:0] FaultOverflow  = 2'd1;
  localparam logic [1:0] FaultUnderflow = 2'd2;
  localparam logic [1:0] FaultIllegal   = 2'd3;

  typedef enum logic [1:0] {StRun, StWaitOut, StHalt} state_e;

endpackage

// File: rtl/mini_alu_core_return_stack.sv
// Return-address LIFO for CALL/RET.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i push an
// entry; pop_i drops the top entry; data_o is the current top; full_o, empty_o
// and depth_o report occupancy. Push and pop are never asserted together.
module return_stack #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           data_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] depth_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned IdxW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  top_cnt;

  assign top_cnt = cnt_q - CntW'(1);
  assign data_o  = mem_q[top_cnt[IdxW-1:0]];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign depth_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= top_cnt;
    end
  end

  // Storage is not reset; only the occupancy count matters after reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[cnt_q[IdxW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// Two-stage (fetch / execute) register machine with return stack and a
// valid/ready peripheral output port.
// Ports: Clock/Reset_n; oIP fetch address to the external async ROM and
// iInstruction its data; oOutValid/oOutData/oOutTag/iOutReady peripheral
// write handshake; oLed LED register; oHalted, oFault (sticky) and
// oStackDepth status.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned IP_W        = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                             Clock,
  input  logic                             Reset_n,
  output logic [IP_W-1:0]                  oIP,
  input  logic [27:0]                      iInstruction,
  output logic                             oOutValid,
  output logic [DATA_W-1:0]                oOutData,
  output logic [7:0]                       oOutTag,
  input  logic                             iOutReady,
  output logic [7:0]                       oLed,
  output logic                             oHalted,
  output logic [1:0]                       oFault,
  output logic [$clog2(STACK_DEPTH+1)-1:0] oStackDepth
);

  state_e             state_q, state_d;
  logic [IP_W-1:0]    ip_q, ip_d;       // fetch address
  logic [IP_W-1:0]    ex_ip_q, ex_ip_d; // address of the instruction in ir_q
  logic [InstrW-1:0]  ir_q, ir_d;
  logic [7:0]         led_q, led_d;
  logic [1:0]         fault_q, fault_d;
  logic [DATA_W-1:0]  rf_q [2**REG_AW];

  logic [3:0]         op;
  logic [7:0]         dst, src1, src0;
  logic [15:0]        imm;
  logic [DATA_W-1:0]  src1_val, src0_val;

  logic               rf_we;
  logic [DATA_W-1:0]  rf_wdata;
  logic               push, pop, stk_full, stk_empty;
  logic [IP_W-1:0]    stk_top;
  logic               stop, redirect, fetch_next;
  logic [1:0]         fault_code;
  logic [IP_W-1:0]    target;

  assign op   = ir_q[OpMsb:OpLsb];
  assign dst  = ir_q[DstMsb:DstLsb];
  assign src1 = ir_q[Src1Msb:Src1Lsb];
  assign src0 = ir_q[Src0Msb:Src0Lsb];
  assign imm  = {src1, src0};

  assign src1_val = rf_q[src1[REG_AW-1:0]];
  assign src0_val = rf_q[src0[REG_AW-1:0]];

  // ir_q holds OUT for the whole stall and is NOP while halted.
  assign oOutValid = (op == OpOut);
  assign oOutData  = oOutValid ? src0_val : '0;
  assign oOutTag   = oOutValid ? dst : '0;
  assign oIP       = ip_q;
  assign oLed      = led_q;
  assign oHalted   = (state_q == StHalt);
  assign oFault    = fault_q;

  return_stack #(
    .Depth (STACK_DEPTH),
    .Width (IP_W)
  ) u_return_stack (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (ex_ip_q + IP_W'(1)),
    .data_o  (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .depth_o (oStackDepth)
  );

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    ir_d       = ir_q;
    ex_ip_d    = ex_ip_q;
    led_d      = led_q;
    fault_d    = fault_q;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    push       = 1'b0;
    pop        = 1'b0;
    stop       = 1'b0;
    redirect   = 1'b0;
    fetch_next = 1'b0;
    fault_code = FaultNone;
    target     = '0;

    unique case (state_q)
      StRun: begin
        fetch_next = 1'b1;
        case (op)
          OpNop: ;
          OpAdd: begin rf_we = 1'b1; rf_wdata = src1_val + src0_val; end
          OpSub: begin rf_we = 1'b1; rf_wdata = src1_val - src0_val; end
          OpMul: begin rf_we = 1'b1; rf_wdata = src1_val * src0_val; end
          OpSto: begin rf_we = 1'b1; rf_wdata = DATA_W'(imm); end
          OpBle: begin redirect = (src1_val <= src0_val); target = IP_W'(dst); end
          OpBeq: begin redirect = (src1_val == src0_val); target = IP_W'(dst); end
          OpJmp: begin redirect = 1'b1; target = IP_W'(imm); end
          OpCall: begin
            if (stk_full) begin
              stop       = 1'b1;
              fault_code = FaultOverflow;
            end else begin
              push     = 1'b1;
              redirect = 1'b1;
              target   = IP_W'(imm);
            end
          end
          OpRet: begin
            if (stk_empty) begin
              stop       = 1'b1;
              fault_code = FaultUnderflow;
            end else begin
              pop      = 1'b1;
              redirect = 1'b1;
              target   = stk_top;
            end
          end
          OpLed: led_d = src0_val[7:0];
          OpOut: begin
            if (!iOutReady) begin
              state_d    = StWaitOut;
              fetch_next = 1'b0;
            end
          end
          OpHalt: stop = 1'b1;
          default: begin
            stop       = 1'b1;
            fault_code = FaultIllegal;
          end
        endcase
      end
      StWaitOut: begin
        if (iOutReady) begin
          state_d    = StRun;
          fetch_next = 1'b1;
        end
      end
      StHalt: ;
      default: ;
    endcase

    if (stop) begin
      // IP freezes and the pipeline drains to NOP; first fault wins.
      state_d = StHalt;
      ir_d    = InstrNop;
      if (fault_q == FaultNone) begin
        fault_d = fault_code;
      end
    end else if (redirect) begin
      // Squash the wrong-path instruction already fetched.
      ip_d = target;
      ir_d = InstrNop;
    end else if (fetch_next) begin
      ir_d    = iInstruction;
      ex_ip_d = ip_q;
      ip_d    = ip_q + IP_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StRun;
      ip_q    <= '0;
      ex_ip_q <= '0;
      ir_q    <= InstrNop;
      led_q   <= '0;
      fault_q <= FaultNone;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      ex_ip_q <= ex_ip_d;
      ir_q    <= ir_d;
      led_q   <= led_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (rf_we) begin
      rf_q[dst[REG_AW-1:0]] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mini_alu_core.sv
module tb_mini_alu_core;
  import mini_alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        iOutReady;
  logic [27:0] rom  [256];
  logic [27:0] rom2 [256];

  always #5 Clock = ~Clock;

  // Default-parameter core
  logic [15:0] oIP, oOutData;
  logic [27:0] iInstruction;
  logic        oOutValid, oHalted;
  logic [7:0]  oOutTag, oLed;
  logic [1:0]  oFault;
  logic [3:0]  oStackDepth;

  // STACK_DEPTH = 2 core for the overflow case
  logic [15:0] ip2, data2;
  logic [27:0] instr2;
  logic        valid2, halted2;
  logic [7:0]  tag2, led2;
  logic [1:0]  fault2;
  logic [1:0]  depth2;

  assign iInstruction = rom[oIP[7:0]];
  assign instr2       = rom2[ip2[7:0]];

  mini_alu_core dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .oOutValid    (oOutValid),
    .oOutData     (oOutData),
    .oOutTag      (oOutTag),
    .iOutReady    (iOutReady),
    .oLed         (oLed),
    .oHalted      (oHalted),
    .oFault       (oFault),
    .oStackDepth  (oStackDepth)
  );

  mini_alu_core #(.STACK_DEPTH(2)) dut2 (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .oIP          (ip2),
    .iInstruction (instr2),
    .oOutValid    (valid2),
    .oOutData     (data2),
    .oOutTag      (tag2),
    .iOutReady    (iOutReady),
    .oLed         (led2),
    .oHalted      (halted2),
    .oFault       (fault2),
    .oStackDepth  (depth2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] ins_i(input logic [3:0] op, input logic [7:0] d,
                                        input logic [15:0] imm);
    return {op, d, imm};
  endfunction

  task automatic apply_reset();
    Reset_n   = 1'b0;
    iOutReady = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rom[i]  = '0;
      rom2[i] = '0;
    end
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic release_reset();
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       found;
    logic [7:0] tag;
    int         nvalid, nacc;
    int         exp_d [6];

    // Branch vectors give 2 when taken, 1 when not taken.
    vecs[0]  = '{OpAdd, 16'd5,     16'd7,   16'h000C};
    vecs[1]  = '{OpAdd, 16'hFFFF,  16'd2,   16'h0001};
    vecs[2]  = '{OpSub, 16'd5,     16'd7,   16'hFFFE};
    vecs[3]  = '{OpSub, 16'd9,     16'd4,   16'h0005};
    vecs[4]  = '{OpMul, 16'd300,   16'd300, 16'h5F90};
    vecs[5]  = '{OpMul, 16'd7,     16'd6,   16'd42};
    vecs[6]  = '{OpBle, 16'd3,     16'd3,   16'd2};
    vecs[7]  = '{OpBle, 16'd4,     16'd3,   16'd1};
    vecs[8]  = '{OpBle, 16'd2,     16'd3,   16'd2};
    vecs[9]  = '{OpBeq, 16'd3,     16'd3,   16'd2};
    vecs[10] = '{OpBeq, 16'd3,     16'd4,   16'd1};

    // Reset state
    apply_reset();
    check("rst_ip", oIP, 0);
    check("rst_valid", oOutValid, 0);
    check("rst_data", oOutData, 0);
    check("rst_tag", oOutTag, 0);
    check("rst_led", oLed, 0);
    check("rst_halted", oHalted, 0);
    check("rst_fault", oFault, 0);
    check("rst_depth", oStackDepth, 0);

    // Table-driven ALU / branch vectors
    for (int i = 0; i < 11; i++) begin
      apply_reset();
      tag     = 8'hA0 + 8'(i);
      rom[0]  = ins_i(OpSto, 8'd1, vecs[i].a);
      rom[1]  = ins_i(OpSto, 8'd2, vecs[i].b);
      rom[2]  = ins_i(OpSto, 8'd3, 16'd1);
      if (vecs[i].op == OpBle || vecs[i].op == OpBeq) rom[3] = ins(vecs[i].op, 8'd5, 8'd1, 8'd2);
      else rom[3] = ins(vecs[i].op, 8'd3, 8'd1, 8'd2);
      rom[4]  = ins_i(OpJmp, 8'd0, 16'd6);
      rom[5]  = ins_i(OpSto, 8'd3, 16'd2);
      rom[6]  = ins(OpOut, tag, 8'd0, 8'd3);
      rom[7]  = ins(OpHalt, 8'd0, 8'd0, 8'd0);
      release_reset();
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
        step();
        if (oOutValid) found = 1'b1;
      end
      check($sformatf("vec%0d_out_seen", i), found, 1);
      if (found) begin
        check($sformatf("vec%0d_data", i), oOutData, vecs[i].exp);
        check($sformatf("vec%0d_tag", i), oOutTag, tag);
      end
      repeat (3) step();
      check($sformatf("vec%0d_halted", i), oHalted, 1);
      check($sformatf("vec%0d_fault", i), oFault, 0);
    end

    // LED timing: LED executes in cycle 5, oLed visible in cycle 6
    apply_reset();
    rom[0] = ins_i(OpSto, 8'd1, 16'd5);
    rom[1] = ins_i(OpSto, 8'd2, 16'd7);
    rom[2] = ins(OpAdd, 8'd3, 8'd2, 8'd1);
    rom[3] = ins(OpLed, 8'd0, 8'd0, 8'd3);
    rom[4] = ins(OpSub, 8'd4, 8'd1, 8'd2);
    rom[5] = ins(OpOut, 8'h11, 8'd0, 8'd4);
    rom[6] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    release_reset();
    repeat (4) step();
    check("led_before", oLed, 0);
    step();
    check("led_cycle6", oLed, 8'h0C);
    step();
    check("sub_valid", oOutValid, 1);
    check("sub_data", oOutData, 16'hFFFE);

    // Taken BLE: wrong-path LED squashed, target LED visible 2 cycles later
    apply_reset();
    rom[0] = ins_i(OpSto, 8'd1, 16'd3);
    rom[1] = ins_i(OpSto, 8'd0, 16'd3);
    rom[2] = ins_i(OpSto, 8'd6, 16'h55);
    rom[3] = ins(OpBle, 8'd8, 8'd1, 8'd0);
    rom[4] = ins(OpLed, 8'd0, 8'd0, 8'd1);
    rom[5] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    rom[8] = ins(OpLed, 8'd0, 8'd0, 8'd6);
    rom[9] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    release_reset();
    repeat (6) step();
    check("ble_taken_bubble", oLed, 0);
    step();
    check("ble_taken_target", oLed, 8'h55);

    // Untaken BLE: fall-through LED in the very next cycle
    apply_reset();
    rom[0] = ins_i(OpSto, 8'd1, 16'd4);
    rom[1] = ins_i(OpSto, 8'd0, 16'd3);
    rom[2] = ins_i(OpSto, 8'd6, 16'h55);
    rom[3] = ins(OpBle, 8'd8, 8'd1, 8'd0);
    rom[4] = ins(OpLed, 8'd0, 8'd0, 8'd1);
    rom[5] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    release_reset();
    repeat (6) step();
    check("ble_untaken_led", oLed, 8'h04);

    // Nested CALL/RET three deep
    apply_reset();
    rom[0]  = ins_i(OpCall, 8'd0, 16'd10);
    rom[1]  = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    rom[10] = ins_i(OpCall, 8'd0, 16'd20);
    rom[11] = ins(OpRet, 8'd0, 8'd0, 8'd0);
    rom[20] = ins_i(OpCall, 8'd0, 16'd30);
    rom[21] = ins(OpRet, 8'd0, 8'd0, 8'd0);
    rom[30] = ins(OpRet, 8'd0, 8'd0, 8'd0);
    exp_d = '{1, 2, 3, 2, 1, 0};
    release_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 2 == 0) check($sformatf("call_depth_e%0d", k), oStackDepth, exp_d[k/2-1]);
    end
    repeat (3) step();
    check("call_halted", oHalted, 1);
    check("call_fault", oFault, 0);
    check("call_final_ip", oIP, 2);

    // Overflow on the two-entry stack
    apply_reset();
    rom2[0]  = ins_i(OpCall, 8'd0, 16'd10);
    rom2[10] = ins_i(OpCall, 8'd0, 16'd20);
    rom2[20] = ins_i(OpCall, 8'd0, 16'd30);
    rom2[30] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    release_reset();
    repeat (10) step();
    check("ovf_halted", halted2, 1);
    check("ovf_fault", fault2, 1);
    check("ovf_ip", ip2, 21);
    check("ovf_depth", depth2, 2);

    // OUT stalled four cycles
    apply_reset();
    rom[0] = ins_i(OpSto, 8'd1, 16'h1234);
    rom[1] = ins(OpOut, 8'h5A, 8'd0, 8'd1);
    rom[2] = ins(OpLed, 8'd0, 8'd0, 8'd1);
    rom[3] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    iOutReady = 1'b0;
    release_reset();
    nvalid = 0;
    nacc   = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      iOutReady = (k + 1 >= 7);
      #1;
      if (oOutValid) begin
        nvalid++;
        check($sformatf("out_data_c%0d", k + 1), oOutData, 16'h1234);
        check($sformatf("out_tag_c%0d", k + 1), oOutTag, 8'h5A);
        if (iOutReady) nacc++;
      end
      if (k + 1 == 5) check("out_ip_frozen", oIP, 2);
      if (k + 1 == 8) check("out_led_c8", oLed, 0);
      if (k + 1 == 9) check("out_led_c9", oLed, 8'h34);
    end
    check("out_valid_cycles", nvalid, 5);
    check("out_accepts", nacc, 1);

    // RET on empty stack, then an illegal opcode behind it
    apply_reset();
    rom[0] = ins(OpRet, 8'd0, 8'd0, 8'd0);
    rom[1] = ins(4'hC, 8'd0, 8'd0, 8'd0);
    release_reset();
    repeat (6) step();
    check("udf_halted", oHalted, 1);
    check("udf_fault", oFault, 2);
    check("udf_ip", oIP, 1);

    // Illegal opcode
    apply_reset();
    rom[1] = ins(4'hC, 8'd0, 8'd0, 8'd0);
    rom[2] = ins(OpRet, 8'd0, 8'd0, 8'd0);
    release_reset();
    repeat (6) step();
    check("ill_halted", oHalted, 1);
    check("ill_fault", oFault, 3);
    check("ill_ip", oIP, 2);

    // Reset pulsed during WAIT_OUT
    apply_reset();
    rom[0] = ins_i(OpSto, 8'd1, 16'hBEEF);
    rom[1] = ins(OpOut, 8'h77, 8'd0, 8'd1);
    rom[2] = ins(OpHalt, 8'd0, 8'd0, 8'd0);
    iOutReady = 1'b0;
    release_reset();
    repeat (4) step();
    check("wrst_stalled", oOutValid, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("wrst_valid", oOutValid, 0);
    check("wrst_data", oOutData, 0);
    check("wrst_tag", oOutTag, 0);
    check("wrst_ip", oIP, 0);
    iOutReady = 1'b1;
    release_reset();
    #1;
    check("wrst_restart_ip0", oIP, 0);
    step();
    check("wrst_restart_ip1", oIP, 1);
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      if (oOutValid && iOutReady) begin
        nacc++;
        check("wrst_data_after", oOutData, 16'hBEEF);
      end
      step();
    end
    check("wrst_accepts", nacc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_alu_core.md
# mini_alu_core

Parametrised successor to the MiniAlu datapath: a two-stage (fetch / execute) accumulator-free register machine with configurable data width, register-file depth and a hardware return-address stack. Peripherals (LCD, VGA, LED) use one generic valid/ready output port instead of busy-wait branch loops. It sits between the instruction ROM and the peripheral controllers; the ROM stays external and asynchronous-read.

## Interface
Parameters:
- DATA_W, 16: register and datapath width; minimum 16.
- REG_AW, 4: register-file address bits; 2**REG_AW registers; operand fields use their low REG_AW bits.
- IP_W, 16: instruction-pointer width.
- STACK_DEPTH, 8: return-stack entries; minimum 2.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- oIP  out  IP_W  fetch address to the ROM.
- iInstruction  in  28  ROM data for oIP, same cycle. Fields: op[27:24], dst[23:16], src1[15:8], src0[7:0]; imm = {src1,src0}.
- oOutValid  out  1  peripheral write request.
- oOutData  out  DATA_W  value of reg[src0].
- oOutTag  out  8  dst field, used for peripheral select.
- iOutReady  in  1  peripheral accepts when high together with oOutValid.
- oLed  out  8  LED register.
- oHalted  out  1  core stopped.
- oFault  out  2  sticky fault: 0 none, 1 stack overflow, 2 stack underflow, 3 illegal opcode.
- oStackDepth  out  $clog2(STACK_DEPTH+1)  current stack occupancy.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 ADD: reg[dst] = reg[src1] + reg[src0].
  - 2 SUB: reg[dst] = reg[src1] - reg[src0].
  - 3 STO: reg[dst] = zero-extended imm.
  - 4 BLE: if reg[src1] <= reg[src0] (unsigned), IP = dst.
  - 5 JMP: IP = imm.
  - 6 CALL: push return IP, then IP = imm.
  - 7 RET: IP = pop.
  - 8 LED: oLed = reg[src0][7:0].
  - 9 MUL: reg[dst] = low DATA_W bits of the product.
  - A OUT: peripheral write.
  - B BEQ: like BLE, with an equality test.
  - F HALT.
  - C–E: illegal.
- Arithmetic wraps modulo 2**DATA_W. Branch targets are zero-extended or truncated to IP_W.
- Return IP is the execute-stage IP + 1.
- State machine, with states RUN, WAIT_OUT and HALT:
  - RUN → WAIT_OUT: on OUT when iOutReady is low.
  - WAIT_OUT → RUN: on the first edge where iOutReady is high.
  - RUN → HALT: on HALT, an illegal opcode, CALL with the stack full (fault 1) or RET with the stack empty (fault 2).
  - HALT is left only by reset.
- On HALT entry, the faulting instruction has no architectural effect: no register write, no push or pop, no IP change. The first fault is latched and later faults are ignored.
- OUT: oOutValid is high while OUT is in execute. The transfer completes on the edge where iOutReady is high. During WAIT_OUT, IP and the instruction register are frozen and oOutData/oOutTag are held stable. OUT with iOutReady already high completes in one cycle with no stall.
- Register-file reads are combinational in execute; writes happen at the end of execute. Back-to-back dependent instructions therefore see updated values with no hazard logic.

## Timing
- Reset values: oIP 0, instruction register NOP, oLed 0, oOutValid 0, oOutData 0, oOutTag 0, oHalted 0, oFault 0, oStackDepth 0, state RUN. Register-file contents are not reset.
- After Reset_n deasserts, instruction 0 executes in the 2nd cycle.
- Throughput is 1 instruction/cycle.
- Taken branch, JMP, CALL and RET: 1-cycle penalty. The wrong-path instruction in the fetch register is replaced with NOP; the target executes 2 cycles after the branch.
- Untaken branches have no penalty.
- oHalted rises on the edge that ends the halting instruction; oIP freezes at that point.
- Reset asserted mid-stall drops oOutValid immediately (asynchronous). No transfer is counted.

## Structure
- Package mini_alu_pkg holds:
  - the opcode localparams;
  - the field bit positions;
  - the fault codes;
  - the state encoding.
- One sub-module, return_stack: a LIFO of STACK_DEPTH × IP_W with push/pop, full/empty flags and depth count. Simultaneous push and pop never occur.
- The register file is inferred inside the core.

## Test plan
- Reset, then `STO r1,5`; `STO r2,7`; `ADD r3,r2,r1`; `LED r3` → oLed = 0x0C at cycle 6; `SUB r4,r1,r2` gives 0xFFFE at DATA_W=16.
- `BLE` with r1 = 3, r0 = 3 → taken: one NOP bubble, and the target's effect is visible 2 cycles later. With r1 = 4 the branch is not taken and there is no bubble.
- Nested CALL/RET at 3 levels → correct returns, oStackDepth goes 1, 2, 3, 2, 1, 0. With STACK_DEPTH = 2, a third CALL → oHalted = 1, oFault = 1, oIP frozen.
- `OUT` with iOutReady held low for 4 cycles:
  - oOutValid is high for 5 cycles, with data and tag stable;
  - exactly one accepted transfer;
  - the next instruction executes the cycle after acceptance.
- RET on an empty stack → fault 2. Opcode 0xC → fault 3. A second fault does not overwrite oFault.
- Reset_n pulsed low during WAIT_OUT → every output returns to its reset value asynchronously, and execution restarts at IP 0.
